// File: rtl/soc_axi_pkg.sv
// Shared AXI4 fabric definitions for the RAM responder: widths, encodings, FSM states,
// the read-buffer entry layout and the burst address generator.
package soc_axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_RESP,
    ST_READ,
    ST_READ_DRAIN
  } state_e;

  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_e;

  // 39-bit read response entry: {rdata, rresp, rid, rlast}
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic [ID_W-1:0]   id;
    logic              last;
  } rbuf_t;

  // Next beat address; the reserved burst encoding behaves as INCR.
  function automatic logic [ADDR_W-1:0] axi_next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [1:0]        burst,
    input logic [LEN_W-1:0]  len
  );
    logic [ADDR_W-1:0] mask;
    mask = (({{(ADDR_W-LEN_W){1'b0}}, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      AXI_BURST_FIXED: return addr;
      AXI_BURST_WRAP:  return (addr & ~mask) | ((addr + 32'd4) & mask);
      default:         return addr + 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/soc_axi_ram_resp_fifo.sv
// Two-entry read response buffer between the RAM return path and the AXI R channel;
// count is exported so the read issue logic never overruns it.
module soc_axi_ram_resp_fifo
  import soc_axi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  rbuf_t      push_data_i,
  output logic       accept_o,
  output logic       valid_o,
  input  logic       pop_i,
  output rbuf_t      pop_data_o,
  output logic [1:0] count_o
);

  rbuf_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign accept_o   = (count_q != 2'd2);
  assign valid_o    = (count_q != 2'd0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign do_push    = push_i && accept_o;
  assign do_pop     = pop_i && valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the two entries are cleared too; at this depth it is cheap and keeps rdata_o
      // at a known value out of reset instead of leaking stale read data.
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/soc_axi_ram_responder.sv
// AXI4 slave terminating FIXED/INCR/WRAP bursts onto a single-ported synchronous RAM port.
// One transaction at a time; read/write grants alternate on a tie.
module soc_axi_ram_responder
  import soc_axi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inport_awvalid_i,
  input  logic [ADDR_W-1:0] inport_awaddr_i,
  input  logic [ID_W-1:0]   inport_awid_i,
  input  logic [LEN_W-1:0]  inport_awlen_i,
  input  logic [1:0]        inport_awburst_i,
  output logic              inport_awready_o,
  input  logic              inport_wvalid_i,
  input  logic [DATA_W-1:0] inport_wdata_i,
  input  logic [STRB_W-1:0] inport_wstrb_i,
  input  logic              inport_wlast_i,
  output logic              inport_wready_o,
  output logic              inport_bvalid_o,
  output logic [1:0]        inport_bresp_o,
  output logic [ID_W-1:0]   inport_bid_o,
  input  logic              inport_bready_i,
  input  logic              inport_arvalid_i,
  input  logic [ADDR_W-1:0] inport_araddr_i,
  input  logic [ID_W-1:0]   inport_arid_i,
  input  logic [LEN_W-1:0]  inport_arlen_i,
  input  logic [1:0]        inport_arburst_i,
  output logic              inport_arready_o,
  output logic              inport_rvalid_o,
  output logic [DATA_W-1:0] inport_rdata_o,
  output logic [1:0]        inport_rresp_o,
  output logic [ID_W-1:0]   inport_rid_o,
  output logic              inport_rlast_o,
  input  logic              inport_rready_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [STRB_W-1:0] ram_wr_o,
  output logic              ram_rd_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  state_e            state_q, state_d;
  grant_e            last_grant_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [1:0]        burst_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic aw_grant, ar_grant, aw_hs, ar_hs;
  logic w_beat, last_beat, rd_issue, rd_pop;
  logic fifo_accept, fifo_valid, fifo_push;
  logic [1:0] fifo_count;
  logic [2:0] rbuf_used;
  rbuf_t fifo_in, fifo_out;
  logic wlast_unused;

  // Bursts end on the beat count alone, so wlast carries no information here.
  assign wlast_unused = inport_wlast_i;

  assign aw_grant  = inport_awvalid_i && (!inport_arvalid_i || last_grant_q == GRANT_READ);
  assign ar_grant  = inport_arvalid_i && (!inport_awvalid_i || last_grant_q == GRANT_WRITE);
  assign aw_hs     = inport_awvalid_i && inport_awready_o;
  assign ar_hs     = inport_arvalid_i && inport_arready_o;
  assign last_beat = (beat_q == len_q);
  assign w_beat    = (state_q == ST_WRITE) && inport_wvalid_i;
  assign rd_pop    = fifo_valid && inport_rready_i;
  assign rbuf_used = {1'b0, fifo_count} + {2'b00, inflight_q};
  // A slot freed by this cycle's pop is reusable at once, sustaining one read beat per cycle.
  assign rd_issue  = (state_q == ST_READ) && (rbuf_used < (3'd2 + {2'b00, rd_pop}));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs)      state_d = ST_WRITE;
        else if (ar_hs) state_d = ST_READ;
      end
      ST_WRITE:      if (w_beat && last_beat)       state_d = ST_WRITE_RESP;
      ST_WRITE_RESP: if (inport_bready_i)           state_d = ST_IDLE;
      ST_READ:       if (rd_issue && last_beat)     state_d = ST_READ_DRAIN;
      ST_READ_DRAIN: if (rd_pop && fifo_out.last)   state_d = ST_IDLE;
      default:                                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    inport_awready_o = 1'b0;
    inport_arready_o = 1'b0;
    inport_wready_o  = 1'b0;
    inport_bvalid_o  = 1'b0;
    ram_wr_o         = '0;
    ram_wdata_o      = '0;
    ram_rd_o         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inport_awready_o = aw_grant;
        inport_arready_o = ar_grant;
      end
      ST_WRITE: begin
        inport_wready_o = 1'b1;
        if (inport_wvalid_i) begin
          ram_wr_o    = inport_wstrb_i;
          ram_wdata_o = inport_wdata_i;
        end
      end
      ST_WRITE_RESP: inport_bvalid_o = 1'b1;
      ST_READ:       ram_rd_o        = rd_issue;
      default: ;
    endcase
  end

  assign ram_addr_o     = {cur_addr_q[ADDR_W-1:2], 2'b00};
  assign inport_bresp_o = AXI_RESP_OKAY;
  assign inport_bid_o   = id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q    <= GRANT_READ;
      cur_addr_q      <= '0;
      id_q            <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      burst_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values,
      // independent of statement order.
      inflight_q <= rd_issue;
      if (rd_issue) inflight_last_q <= last_beat;
      if (aw_hs || ar_hs) begin
        cur_addr_q   <= aw_hs ? inport_awaddr_i  : inport_araddr_i;
        id_q         <= aw_hs ? inport_awid_i    : inport_arid_i;
        len_q        <= aw_hs ? inport_awlen_i   : inport_arlen_i;
        burst_q      <= aw_hs ? inport_awburst_i : inport_arburst_i;
        beat_q       <= '0;
        last_grant_q <= aw_hs ? GRANT_WRITE : GRANT_READ;
      end else if (w_beat || rd_issue) begin
        cur_addr_q <= axi_next_addr(cur_addr_q, burst_q, len_q);
        beat_q     <= beat_q + 8'd1;
      end
    end
  end

  // RAM data returns one cycle after the issue and is tagged with that beat's rlast.
  assign fifo_in   = '{data: ram_rdata_i, resp: AXI_RESP_OKAY, id: id_q, last: inflight_last_q};
  assign fifo_push = inflight_q && fifo_accept;

  soc_axi_ram_resp_fifo u_rbuf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .accept_o    (fifo_accept),
    .valid_o     (fifo_valid),
    .pop_i       (rd_pop),
    .pop_data_o  (fifo_out),
    .count_o     (fifo_count)
  );

  assign inport_rvalid_o = fifo_valid;
  assign inport_rdata_o  = fifo_out.data;
  assign inport_rresp_o  = fifo_out.resp;
  assign inport_rid_o    = fifo_out.id;
  assign inport_rlast_o  = fifo_out.last;

endmodule

// File: tb/tb_soc_axi_ram_responder.sv
// Directed bench for soc_axi_ram_responder: a word RAM model behind the DUT, monitors that log
// RAM reads and R-channel pops, and one linear sequence of hand-computed checks.
module tb_soc_axi_ram_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready, ram_rd;
  logic [31:0] awaddr, araddr, wdata, rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid, ram_wr;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  beat_t       pop_q[$];
  logic [31:0] rd_q[$];
  int          tot_iss = 0, tot_pop = 0, out_base = 0, out_viol = 0, overlap_cnt = 0;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] mem [256];
  bit          loaded = 1'b0;

  always #5 clk_i = ~clk_i;

  soc_axi_ram_responder dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .inport_awvalid_i (awvalid),
    .inport_awaddr_i  (awaddr),
    .inport_awid_i    (awid),
    .inport_awlen_i   (awlen),
    .inport_awburst_i (awburst),
    .inport_awready_o (awready),
    .inport_wvalid_i  (wvalid),
    .inport_wdata_i   (wdata),
    .inport_wstrb_i   (wstrb),
    .inport_wlast_i   (wlast),
    .inport_wready_o  (wready),
    .inport_bvalid_o  (bvalid),
    .inport_bresp_o   (bresp),
    .inport_bid_o     (bid),
    .inport_bready_i  (bready),
    .inport_arvalid_i (arvalid),
    .inport_araddr_i  (araddr),
    .inport_arid_i    (arid),
    .inport_arlen_i   (arlen),
    .inport_arburst_i (arburst),
    .inport_arready_o (arready),
    .inport_rvalid_o  (rvalid),
    .inport_rdata_o   (rdata),
    .inport_rresp_o   (rresp),
    .inport_rid_o     (rid),
    .inport_rlast_o   (rlast),
    .inport_rready_i  (rready),
    .ram_addr_o       (ram_addr),
    .ram_wr_o         (ram_wr),
    .ram_rd_o         (ram_rd),
    .ram_wdata_o      (ram_wdata),
    .ram_rdata_i      (ram_rdata)
  );

  // Word RAM: each word preloaded with 0xD000_0000 | byte address, read data one cycle after ram_rd.
  always @(posedge clk_i) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | (i * 4);
      loaded = 1'b1;
    end
    for (int b = 0; b < 4; b++)
      if (ram_wr[b]) mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
    if (ram_rd) ram_rdata <= mem[ram_addr[9:2]];
  end

  always @(negedge clk_i) begin
    if (ram_rd) begin
      rd_q.push_back(ram_addr);
      tot_iss++;
    end
    if (ram_rd && ram_wr != 4'h0) overlap_cnt++;
    if (rvalid && rready) begin
      pop_q.push_back('{data: rdata, id: rid, last: rlast});
      tot_pop++;
    end
    if (tot_iss - tot_pop - out_base > 2) out_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    logic got = 1'b0;
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awburst = burst;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = awready;
      tick();
    end
    awvalid = 1'b0;
    check("aw_accept", got, 1);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    logic got = 1'b0;
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arburst = burst;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = arready;
      tick();
    end
    arvalid = 1'b0;
    check("ar_accept", got, 1);
  endtask

  task automatic wait_pops(input int base, input int n);
    for (int i = 0; i < 60 && (pop_q.size() - base) < n; i++) tick();
  endtask

  initial begin
    int p0, r0, v0, ng;
    logic [5:0]  order;
    logic [31:0] ea;

    rst_i = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_outputs", {awready, arready, wready, bvalid, rvalid, ram_rd, ram_wr}, 0);

    // INCR write, 4 beats at 0x100
    tick();
    send_aw(32'h100, 4'h5, 8'd3, 2'b01);
    for (int b = 0; b < 4; b++) begin
      wvalid = 1'b1; wdata = 32'hA0 + b; wstrb = 4'hF; wlast = (b == 3);
      @(negedge clk_i);
      check("wr_incr_beat", {ram_wr, ram_addr, ram_wdata, wready},
            {4'hF, 32'h100 + 32'(4 * b), 32'hA0 + 32'(b), 1'b1});
      tick();
    end
    wvalid = 1'b0;
    @(negedge clk_i);
    check("wr_incr_bresp", {bvalid, bid, bresp}, {1'b1, 4'h5, 2'b00});
    tick();
    @(negedge clk_i);
    check("bvalid_hold", bvalid, 1);
    tick();
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk_i);
    check("bvalid_done", bvalid, 0);

    // FIXED write at 0x40, wlast raised early on beat 0
    tick();
    send_aw(32'h40, 4'h6, 8'd1, 2'b00);
    wvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'h3; wlast = 1'b1;
    @(negedge clk_i);
    check("wr_fixed_beat0", {ram_wr, ram_addr, ram_wdata}, {4'h3, 32'h40, 32'h1111_2222});
    tick();
    wdata = 32'h3333_4444; wstrb = 4'hC;
    @(negedge clk_i);
    check("wr_fixed_beat1", {wready, ram_wr, ram_addr, ram_wdata}, {1'b1, 4'hC, 32'h40, 32'h3333_4444});
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk_i);
    check("wr_fixed_bresp", {bvalid, bid}, {1'b1, 4'h6});
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // WRAP read 0x1C len 3, rready held high
    rready = 1'b1;
    p0 = pop_q.size(); r0 = rd_q.size();
    send_ar(32'h1C, 4'hA, 8'd3, 2'b10);
    @(negedge clk_i);
    check("rd_wrap_first_issue", {ram_rd, ram_addr, rvalid}, {1'b1, 32'h1C, 1'b0});
    tick();
    @(negedge clk_i);
    check("rvalid_ar_plus1", rvalid, 0);
    tick();
    @(negedge clk_i);
    check("rvalid_ar_plus2", {rvalid, rdata}, {1'b1, 32'hD000_001C});
    wait_pops(p0, 4);
    check("rd_wrap_pops", pop_q.size() - p0, 4);
    check("rd_wrap_issues", rd_q.size() - r0, 4);
    for (int i = 0; i < 4; i++) begin
      ea = (i == 0) ? 32'h1C : 32'h10 + 32'(4 * (i - 1));
      check("rd_wrap_addr", rd_q[r0 + i], ea);
      check("rd_wrap_beat", pop_q[p0 + i], {32'hD000_0000 | ea, 4'hA, i == 3});
    end

    // INCR read len 7 with rready toggling every cycle
    out_base = tot_iss - tot_pop; v0 = out_viol;
    p0 = pop_q.size(); r0 = rd_q.size();
    send_ar(32'h200, 4'h3, 8'd7, 2'b01);
    for (int i = 0; i < 80 && (pop_q.size() - p0) < 8; i++) begin
      rready = ~rready;
      tick();
    end
    rready = 1'b1;
    repeat (3) tick();
    check("rd_incr_pops", pop_q.size() - p0, 8);
    check("rd_incr_issues", rd_q.size() - r0, 8);
    check("rd_incr_outstanding", out_viol - v0, 0);
    for (int i = 0; i < 8; i++) begin
      ea = 32'h200 + 32'(4 * i);
      check("rd_incr_addr", rd_q[r0 + i], ea);
      check("rd_incr_beat", pop_q[p0 + i], {32'hD000_0000 | ea, 4'h3, i == 7});
    end

    // Simultaneous AW/AR from reset, three grants
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    p0 = pop_q.size();
    awvalid = 1'b1; awaddr = 32'h80; awid = 4'h1; awlen = 8'd0; awburst = 2'b01;
    arvalid = 1'b1; araddr = 32'h40; arid = 4'h2; arlen = 8'd0; arburst = 2'b01;
    wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1;
    bready = 1'b1; rready = 1'b1;
    order = '0; ng = 0;
    for (int i = 0; i < 40 && ng < 3; i++) begin
      @(negedge clk_i);
      if (awready && arready) order = 6'b111111;
      else if (awready) begin order = {order[3:0], 2'd1}; ng++; end
      else if (arready) begin order = {order[3:0], 2'd2}; ng++; end
      tick();
    end
    awvalid = 1'b0; arvalid = 1'b0;
    repeat (4) tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    check("grant_order_wrw", order, 6'b01_10_01);
    check("grant_read_pops", pop_q.size() - p0, 1);
    check("grant_read_merged", pop_q[p0], {32'h3333_2222, 4'h2, 1'b1});
    check("grant_write_mem", mem[32], 32'h5555_AAAA);
    check("no_rd_wr_overlap", overlap_cnt, 0);

    // Reset in the middle of a 4-beat read
    p0 = pop_q.size();
    send_ar(32'h300, 4'h7, 8'd3, 2'b01);
    wait_pops(p0, 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_flush", {awready, arready, wready, bvalid, rvalid, ram_rd, ram_wr}, 0);
    tick();
    @(negedge clk_i);
    check("rst_no_stray_rvalid", rvalid, 0);
    tick();
    p0 = pop_q.size();
    send_ar(32'h10, 4'h9, 8'd1, 2'b01);
    wait_pops(p0, 2);
    repeat (2) tick();
    check("post_rst_pops", pop_q.size() - p0, 2);
    check("post_rst_beat0", pop_q[p0], {32'hD000_0010, 4'h9, 1'b0});
    check("post_rst_beat1", pop_q[p0 + 1], {32'hD000_0014, 4'h9, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
